// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared encodings for the multi-cycle RV32I control FSM:
//                ALU op codes, opcodes, states, select encodings and the
//                instruction-class enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // ALU operation codes driven on alu_op_o
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_XOR   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_BEQ   = 4'd5;
    localparam logic [3:0] ALU_BNE   = 4'd6;
    localparam logic [3:0] ALU_BLT   = 4'd7;
    localparam logic [3:0] ALU_BGE   = 4'd8;
    localparam logic [3:0] ALU_SLL   = 4'd9;
    localparam logic [3:0] ALU_SRL   = 4'd10;
    localparam logic [3:0] ALU_SRA   = 4'd11;
    localparam logic [3:0] ALU_PASSB = 4'd12;

    // RV32I major opcodes handled by this controller
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Operand / write-back select encodings
    localparam logic [1:0] A_RS1    = 2'd0;
    localparam logic [1:0] A_PC     = 2'd1;
    localparam logic [1:0] A_OLDPC  = 2'd2;
    localparam logic [1:0] B_RS2    = 2'd0;
    localparam logic [1:0] B_IMM    = 2'd1;
    localparam logic [1:0] B_FOUR   = 2'd2;
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC    = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_LUI     = 3'd5,
        CLS_JAL     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_e;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control bus between the multi-cycle controller (master)
//                and the datapath / memory side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [31:0] instr_i;
    logic        mem_ready_i;
    logic        alu_flag_i;
    logic [3:0]  alu_op_o;
    logic [1:0]  alu_a_sel_o;
    logic [1:0]  alu_b_sel_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        mem_addr_sel_o;
    logic        reg_write_o;
    logic [1:0]  wb_sel_o;
    logic        illegal_o;
    logic        done_o;
    logic [2:0]  state_o;

    modport master (
        input  instr_i, mem_ready_i, alu_flag_i,
        output alu_op_o, alu_a_sel_o, alu_b_sel_o, ir_write_o, pc_write_o,
               mem_read_o, mem_write_o, mem_addr_sel_o, reg_write_o,
               wb_sel_o, illegal_o, done_o, state_o
    );

    modport slave (
        output instr_i, mem_ready_i, alu_flag_i,
        input  alu_op_o, alu_a_sel_o, alu_b_sel_o, ir_write_o, pc_write_o,
               mem_read_o, mem_write_o, mem_addr_sel_o, reg_write_o,
               wb_sel_o, illegal_o, done_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Combinational RV32I-subset decoder: instruction class,
//                EXEC-stage ALU op, B-operand select and illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e cls_o,
    output logic [3:0]   alu_op_o,
    output logic [1:0]   b_sel_o,
    output logic         illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [3:0] alu_map;
    logic       alu_map_ok;
    logic       unused_instr_bits;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7_b5 = instr_i[30];
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    // funct3 -> ALU op for R-type and I-ALU; add/sub split only for R-type
    always_comb begin
        alu_map    = ALU_ADD;
        alu_map_ok = 1'b1;
        case (funct3)
            3'b000:  alu_map = (opcode == OPC_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b100:  alu_map = ALU_XOR;
            3'b110:  alu_map = ALU_OR;
            3'b111:  alu_map = ALU_AND;
            3'b001:  alu_map = ALU_SLL;
            3'b101:  alu_map = funct7_b5 ? ALU_SRA : ALU_SRL;
            default: alu_map_ok = 1'b0;   // slt/sltu not supported by the ALU
        endcase
    end

    // opcode classification; anything unrecognised falls to CLS_ILLEGAL
    always_comb begin
        cls_o    = CLS_ILLEGAL;
        alu_op_o = ALU_ADD;
        b_sel_o  = B_RS2;
        case (opcode)
            OPC_R: if (alu_map_ok) begin
                cls_o    = CLS_R;
                alu_op_o = alu_map;
            end
            OPC_I: if (alu_map_ok) begin
                cls_o    = CLS_I;
                alu_op_o = alu_map;
                b_sel_o  = B_IMM;
            end
            OPC_LOAD: if (funct3 == 3'b010) begin
                cls_o   = CLS_LOAD;
                b_sel_o = B_IMM;
            end
            OPC_STORE: if (funct3 == 3'b010) begin
                cls_o   = CLS_STORE;
                b_sel_o = B_IMM;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  begin cls_o = CLS_BRANCH; alu_op_o = ALU_BEQ; end
                    3'b001:  begin cls_o = CLS_BRANCH; alu_op_o = ALU_BNE; end
                    3'b100:  begin cls_o = CLS_BRANCH; alu_op_o = ALU_BLT; end
                    3'b101:  begin cls_o = CLS_BRANCH; alu_op_o = ALU_BGE; end
                    default: cls_o = CLS_ILLEGAL;
                endcase
            end
            OPC_LUI: begin
                cls_o    = CLS_LUI;
                alu_op_o = ALU_PASSB;
                b_sel_o  = B_IMM;
            end
            OPC_JAL: cls_o = CLS_JAL;
            default: cls_o = CLS_ILLEGAL;
        endcase
        if (cls_o == CLS_ILLEGAL) begin
            alu_op_o = ALU_ADD;
            b_sel_o  = B_RS2;
        end
    end

    assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM sequencing fetch, decode, execute,
//                memory access, write-back and PC update for RV32I subset.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_e       state_q, state_d;
    logic         taken_q, taken_d;
    instr_class_e dec_cls;
    logic [3:0]   dec_alu_op;
    logic [1:0]   dec_b_sel;
    logic         dec_illegal;

    instr_decoder u_dec (
        .instr_i   (bus.instr_i),
        .cls_o     (dec_cls),
        .alu_op_o  (dec_alu_op),
        .b_sel_o   (dec_b_sel),
        .illegal_o (dec_illegal)
    );

    // state and branch-taken registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    // next-state and output decode; reset forces every output low
    always_comb begin
        state_d            = state_q;
        taken_d            = taken_q;
        bus.alu_op_o       = ALU_ADD;
        bus.alu_a_sel_o    = A_RS1;
        bus.alu_b_sel_o    = B_RS2;
        bus.ir_write_o     = 1'b0;
        bus.pc_write_o     = 1'b0;
        bus.mem_read_o     = 1'b0;
        bus.mem_write_o    = 1'b0;
        bus.mem_addr_sel_o = 1'b0;
        bus.reg_write_o    = 1'b0;
        bus.wb_sel_o       = WB_ALU;
        bus.illegal_o      = 1'b0;
        bus.done_o         = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read_o  = 1'b1;
                bus.alu_a_sel_o = A_PC;
                bus.alu_b_sel_o = B_FOUR;
                if (bus.mem_ready_i) begin
                    bus.ir_write_o = 1'b1;
                    bus.pc_write_o = 1'b1;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    bus.illegal_o = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_op_o    = dec_alu_op;
                bus.alu_b_sel_o = dec_b_sel;
                case (dec_cls)
                    CLS_R, CLS_I, CLS_LUI: state_d = S_WB;
                    CLS_LOAD, CLS_STORE:   state_d = S_MEM;
                    CLS_BRANCH: begin
                        taken_d = bus.alu_flag_i;
                        state_d = S_BRANCH;
                    end
                    CLS_JAL: begin
                        bus.reg_write_o = 1'b1;
                        bus.wb_sel_o    = WB_PC;
                        taken_d         = 1'b1;
                        state_d         = S_BRANCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                bus.mem_addr_sel_o = 1'b1;
                if (dec_cls == CLS_LOAD) begin
                    bus.mem_read_o = 1'b1;
                    if (bus.mem_ready_i) state_d = S_WB;
                end else begin
                    bus.mem_write_o = 1'b1;
                    if (bus.mem_ready_i) begin
                        bus.done_o = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                bus.reg_write_o = 1'b1;
                bus.wb_sel_o    = (dec_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                bus.done_o      = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_a_sel_o = A_OLDPC;
                bus.alu_b_sel_o = B_IMM;
                bus.pc_write_o  = taken_q;
                bus.done_o      = 1'b1;
                taken_d         = 1'b0;
                state_d         = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            bus.alu_op_o       = 4'd0;
            bus.alu_a_sel_o    = 2'd0;
            bus.alu_b_sel_o    = 2'd0;
            bus.pc_write_o     = 1'b0;
            bus.ir_write_o     = 1'b0;
            bus.mem_read_o     = 1'b0;
            bus.mem_write_o    = 1'b0;
            bus.mem_addr_sel_o = 1'b0;
            bus.reg_write_o    = 1'b0;
            bus.wb_sel_o       = 2'd0;
            bus.illegal_o      = 1'b0;
            bus.done_o         = 1'b0;
        end
    end

    assign bus.state_o = rst ? 3'd0 : state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic clk;
    logic rst;
    int   ncmp;
    int   nfail;
    logic [20:0] e;
    logic [20:0] obs;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_LUI  = 32'h123451B7;
    localparam logic [31:0] I_LW   = 32'h0040A183;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;

    multicycle_ctrl_if u_bus ();

    multicycle_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {u_bus.state_o, u_bus.alu_op_o, u_bus.alu_a_sel_o, u_bus.alu_b_sel_o,
                  u_bus.ir_write_o, u_bus.pc_write_o, u_bus.mem_read_o, u_bus.mem_write_o,
                  u_bus.mem_addr_sel_o, u_bus.reg_write_o, u_bus.wb_sel_o,
                  u_bus.illegal_o, u_bus.done_o};

    // Pack an expected output vector: state, op, a, b, irw, pcw, mrd, mwr, asel, rw, wb, ill, done
    function automatic logic [20:0] ev(input int st, input int op, input int a, input int b,
                                       input int irw, input int pcw, input int mrd, input int mwr,
                                       input int asel, input int rw, input int wb,
                                       input int ill, input int dn);
        return {st[2:0], op[3:0], a[1:0], b[1:0], irw[0], pcw[0], mrd[0], mwr[0],
                asel[0], rw[0], wb[1:0], ill[0], dn[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch and decode with zero-wait memory; returns at the EXEC cycle
    task automatic fetch_decode(input logic [31:0] ins);
        u_bus.instr_i     = ins;
        u_bus.mem_ready_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_bus.instr_i     = I_ADD;
        u_bus.mem_ready_i = 1'b1;
        u_bus.alu_flag_i  = 1'b0;
        tick();
        tick();
        e = ev(0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL reset_hold: got %h want %h", obs, e); end
        rst = 1'b0;
        u_bus.mem_ready_i = 1'b0;
        #1;
        e = ev(0,0,1,2, 0,0,1,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL reset_first_fetch: got %h want %h", obs, e); end
        tick();
    endtask

    task automatic test_add();
        u_bus.instr_i = I_ADD;
        u_bus.mem_ready_i = 1'b1;
        #1;
        e = ev(0,0,1,2, 1,1,1,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL add_fetch: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(1,0,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL add_decode: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(2,0,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL add_exec: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(4,0,0,0, 0,0,0,0, 0,1,0, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL add_wb: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(0,0,1,2, 1,1,1,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL add_refetch: got %h want %h", obs, e); end
    endtask

    task automatic test_alu_ops();
        fetch_decode(I_SUB); #1;
        e = ev(2,1,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL sub_exec: got %h want %h", obs, e); end
        tick(); tick();
        fetch_decode(I_SRAI); #1;
        e = ev(2,11,0,1, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL srai_exec: got %h want %h", obs, e); end
        tick(); tick();
        fetch_decode(I_LUI); #1;
        e = ev(2,12,0,1, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL lui_exec: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(4,0,0,0, 0,0,0,0, 0,1,0, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL lui_wb: got %h want %h", obs, e); end
        tick();
    endtask

    task automatic test_load_wait();
        fetch_decode(I_LW);
        u_bus.mem_ready_i = 1'b0;
        #1;
        e = ev(2,0,0,1, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL lw_exec: got %h want %h", obs, e); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            e = ev(3,0,0,0, 0,0,1,0, 1,0,0, 0,0);
            ncmp++; if (obs !== e) begin nfail++; $display("FAIL lw_mem_wait%0d: got %h want %h", i, obs, e); end
            tick();
        end
        u_bus.mem_ready_i = 1'b1;
        #1;
        e = ev(3,0,0,0, 0,0,1,0, 1,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL lw_mem_ready: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(4,0,0,0, 0,0,0,0, 0,1,1, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL lw_wb: got %h want %h", obs, e); end
        tick();
    endtask

    task automatic test_branch();
        fetch_decode(I_BEQ);
        u_bus.alu_flag_i = 1'b1;
        #1;
        e = ev(2,5,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL beq_exec: got %h want %h", obs, e); end
        tick();
        u_bus.alu_flag_i = 1'b0;
        #1;
        e = ev(5,0,2,1, 0,1,0,0, 0,0,0, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL beq_taken: got %h want %h", obs, e); end
        tick();
        fetch_decode(I_BEQ);
        u_bus.alu_flag_i = 1'b0;
        tick();
        u_bus.alu_flag_i = 1'b1;
        #1;
        e = ev(5,0,2,1, 0,0,0,0, 0,0,0, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL beq_not_taken: got %h want %h", obs, e); end
        tick();
        fetch_decode(I_BNE); #1;
        e = ev(2,6,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL bne_exec: got %h want %h", obs, e); end
        tick(); tick();
    endtask

    task automatic test_jal();
        fetch_decode(I_JAL);
        u_bus.alu_flag_i = 1'b0;
        #1;
        e = ev(2,0,0,0, 0,0,0,0, 0,1,2, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL jal_exec: got %h want %h", obs, e); end
        tick(); #1;
        e = ev(5,0,2,1, 0,1,0,0, 0,0,0, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL jal_branch: got %h want %h", obs, e); end
        tick();
    endtask

    task automatic test_illegal();
        u_bus.instr_i = I_SLT;
        u_bus.mem_ready_i = 1'b1;
        tick(); #1;
        e = ev(1,0,0,0, 0,0,0,0, 0,0,0, 1,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL slt_decode: got %h want %h", obs, e); end
        tick();
        u_bus.mem_ready_i = 1'b0;
        #1;
        e = ev(0,0,1,2, 0,0,1,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL slt_refetch: got %h want %h", obs, e); end
        tick();
    endtask

    task automatic test_store();
        fetch_decode(I_SW); #1;
        e = ev(2,0,0,1, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL sw_exec: got %h want %h", obs, e); end
        u_bus.mem_ready_i = 1'b0;
        tick(); #1;
        e = ev(3,0,0,0, 0,0,0,1, 1,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL sw_mem_wait: got %h want %h", obs, e); end
        tick();
        u_bus.mem_ready_i = 1'b1;
        #1;
        e = ev(3,0,0,0, 0,0,0,1, 1,0,0, 0,1);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL sw_mem_done: got %h want %h", obs, e); end
        tick();
    endtask

    task automatic test_reset_mid();
        fetch_decode(I_SW);
        u_bus.mem_ready_i = 1'b0;
        tick(); #1;
        e = ev(3,0,0,0, 0,0,0,1, 1,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL rstmid_mem: got %h want %h", obs, e); end
        rst = 1'b1;
        tick(); #1;
        e = ev(0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL rstmid_held: got %h want %h", obs, e); end
        rst = 1'b0;
        #1;
        e = ev(0,0,1,2, 0,0,1,0, 0,0,0, 0,0);
        ncmp++; if (obs !== e) begin nfail++; $display("FAIL rstmid_refetch: got %h want %h", obs, e); end
        tick();
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        rst   = 1'b1;
        u_bus.instr_i     = 32'h0;
        u_bus.mem_ready_i = 1'b0;
        u_bus.alu_flag_i  = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_load_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_store();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that drives the ALU: it decodes the instruction held in the datapath IR and issues ALU_op codes plus operand selects. It consumes the ALU's branch flag to resolve branches. It also sequences instruction fetch, memory access, register write-back and PC update for the RV32I subset the ALU supports. It sits between the instruction register/memory interface and the datapath muxes.

Parameters:
none (all encodings are fixed constants in the shared package)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
instr_i  in  32  current IR contents; valid from DECODE onward
mem_ready_i  in  1  memory completes the pending read/write this cycle
alu_flag_i  in  1  ALU branch-condition flag
alu_op_o  out  4  ALU operation: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 beq, 6 bne, 7 blt, 8 bge, 9 sll, 10 srl, 11 sra, 12 pass-B
alu_a_sel_o  out  2  0 rs1, 1 pc, 2 old_pc (PC of current instr)
alu_b_sel_o  out  2  0 rs2, 1 imm, 2 constant 4
ir_write_o  out  1  latch memory read data into IR and PC into old_pc
pc_write_o  out  1  load PC from ALU result
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
mem_addr_sel_o  out  1  0 pc, 1 ALU result register
reg_write_o  out  1  register-file write strobe
wb_sel_o  out  2  0 ALU result, 1 memory data, 2 pc (already old_pc+4)
illegal_o  out  1  one-cycle pulse on unsupported instruction
done_o  out  1  one-cycle pulse on final cycle of a legal instruction
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5. The state register is the only storage besides 1-bit taken.
- Outputs are decoded combinationally from state and instr_i. Unlisted strobes are 0; unlisted selects are 0.
- rst high: next state FETCH, taken cleared. While rst is high, all outputs are 0 and state_o=0. The first fetch request appears the cycle after rst falls.
- Reset mid-instruction abandons the instruction with no further writes.
- FETCH: mem_read=1, addr_sel=0, a=pc, b=4, op add. It holds until mem_ready_i. In the mem_ready_i cycle, ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: one cycle with no strobes. Illegal instructions pulse illegal_o and go to FETCH (PC already advanced). All others go to EXEC.
- EXEC by class:
  - R-type (0110011): a=rs1, b=rs2 -> WB. funct3 000 is add/sub by funct7[5]; 100 xor; 110 or; 111 and; 001 sll; 101 srl/sra by funct7[5]. funct3 010/011 is illegal.
  - I-ALU (0010011): same mapping with b=imm. funct3 000 is always add. 010/011 is illegal.
  - lw (0000011, funct3 010) and sw (0100011, funct3 010): op add, a=rs1, b=imm -> MEM.
  - Branch (1100011): funct3 000/001/100/101 map to op 5/6/7/8, a=rs1, b=rs2. Latch taken<=alu_flag_i -> BRANCH. Other funct3 values are illegal.
  - lui (0110111): op 12, b=imm -> WB.
  - jal (1101111): reg_write=1, wb_sel=2; set taken<=1 -> BRANCH.
  - Any other opcode is illegal.
- MEM: addr_sel=1. For a load, mem_read=1 until mem_ready_i, then go to WB. For a store, mem_write=1 until mem_ready_i, with done_o in the mem_ready_i cycle, then go to FETCH. Memory requests stay asserted with no timeout.
- WB: reg_write=1 for exactly one cycle. wb_sel=1 for loads, else 0. done_o=1, then go to FETCH.
- BRANCH: a=old_pc, b=imm, op add, pc_write=taken, done_o=1, then go to FETCH. Taken is cleared on exit.
- alu_flag_i is used only in EXEC of a branch and is ignored in every other state.
- Cycle counts with zero-wait memory: ALU/lui 4, load 5, store 4, branch/jal 4. Each memory wait cycle adds one.

Decomposition:
- Package ctrl_pkg: ALU op codes, RV32I opcode constants, state encoding, a/b/wb select encodings, instruction-class enum.
- Sub-module instr_decoder (combinational): takes instr_i and produces the class, EXEC alu_op, b_sel and illegal. The FSM stays in multicycle_ctrl.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready_i=1 -> states 0,1,2,4. EXEC shows alu_op=0, a=0, b=0. WB shows reg_write=1, wb_sel=0, done_o=1. Total 4 cycles, then FETCH again.
- sub 0x402081B3 -> EXEC alu_op=1. srai 0x4020D193 -> alu_op=11, b=1. lui 0x123451B7 -> alu_op=12, WB reg_write.
- lw 0x0040A183 with mem_ready_i low 3 cycles in MEM -> mem_read_o held 4 cycles, addr_sel=1, then WB with wb_sel=1. Total 8 cycles.
- beq 0x00208463 with alu_flag_i=1 in EXEC -> BRANCH pc_write=1, a=2, b=1, op 0. Repeat with flag 0 -> pc_write=0. bne 0x00209463 -> EXEC alu_op=6.
- jal 0x008000EF -> EXEC reg_write=1, wb_sel=2. BRANCH pc_write=1 regardless of alu_flag_i.
- slt 0x0020A1B3 -> illegal_o pulse in DECODE with no reg/mem/pc writes after fetch, then FETCH. Separately, assert rst during MEM of sw -> next cycle all outputs 0 and state 0; the request resumes fetch after rst falls.
